dm_host_ctrl: RTL and testbench

Synthesizable host-side harness controller for the `toplevel` processor. It takes ownership of the processor's data memory port, clears all 256 bytes, and applies host-supplied preload writes. It then drives the processor's `START` (held-in-reset) line, waits for `DONE`, and streams a result window of data memory back to the host. It sits between an external host stream interface and the `toplevel` `START`/`DONE` pins plus a muxed data-memory port.

---
 rtl/host_pkg.sv | 15 +
 rtl/dm_host_ctrl.sv | 157 +++++++++++++++
 tb/tb_dm_host_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_pkg.sv
// Shared types and constants for the host-side harness controller.
package host_pkg;

  localparam int unsigned DM_DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    HOLD,
    RUN,
    DUMP
  } host_state_e;

endpackage

// File: rtl/dm_host_ctrl.sv
// Host harness controller: clears and preloads data memory, runs the CPU,
// then streams a result window of data memory back to the host.
module dm_host_ctrl
  import host_pkg::*;
#(
  parameter int unsigned DUMP_BASE  = 5,
  parameter int unsigned DUMP_LEN   = 4,
  parameter int unsigned START_HOLD = 2,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       GO,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [7:0] IN_ADDR,
  input  logic [7:0] IN_DATA,
  input  logic       IN_LAST,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [7:0] OUT_DATA,
  output logic       OUT_LAST,
  output logic       DM_OWN,
  output logic       DM_WE,
  output logic [7:0] DM_ADDR,
  output logic [7:0] DM_WDATA,
  input  logic [7:0] DM_RDATA,
  output logic       CPU_START,
  input  logic       CPU_DONE,
  output logic       BUSY,
  output logic       ERR
);

  localparam logic [7:0] CLR_LAST  = 8'(DM_DEPTH - 1);
  localparam logic [7:0] DUMP_LAST = 8'(DUMP_LEN - 1);
  localparam logic [7:0] BASE      = 8'(DUMP_BASE);

  host_state_e state;
  logic [7:0]  idx;
  logic [31:0] tcnt;
  logic        dm_own_q, dm_we_q, in_ready_q, out_valid_q, out_last_q;
  logic        cpu_start_q, busy_q, err_q;
  logic [7:0]  dm_addr_q, dm_wdata_q;
  logic        load_acc;

  // A preload beat writes memory in the cycle it is accepted.
  assign load_acc  = (state == LOAD) && IN_VALID && in_ready_q;
  assign DM_WE     = (state == LOAD) ? load_acc : dm_we_q;
  assign DM_ADDR   = (state == LOAD) ? IN_ADDR  : dm_addr_q;
  assign DM_WDATA  = (state == LOAD) ? IN_DATA  : dm_wdata_q;
  assign OUT_DATA  = DM_RDATA;
  assign DM_OWN    = dm_own_q;
  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;
  assign CPU_START = cpu_start_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;

  // Sequencer with registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      idx         <= 8'd0;
      tcnt        <= 32'd0;
      cpu_start_q <= 1'b1;
      dm_own_q    <= 1'b1;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= 8'd0;
      dm_wdata_q  <= 8'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (GO) begin
            state      <= CLEAR;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            dm_we_q    <= 1'b1;
            dm_addr_q  <= 8'd0;
            dm_wdata_q <= 8'd0;
            idx        <= 8'd0;
          end
        end
        CLEAR: begin
          if (idx == CLR_LAST) begin
            state      <= LOAD;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= 8'd0;
            in_ready_q <= 1'b1;
          end else begin
            idx       <= idx + 8'd1;
            dm_addr_q <= idx + 8'd1;
          end
        end
        LOAD: begin
          if (load_acc && IN_LAST) begin
            state      <= HOLD;
            in_ready_q <= 1'b0;
            dm_own_q   <= 1'b0;
            tcnt       <= 32'd0;
          end
        end
        HOLD: begin
          if (tcnt == START_HOLD - 32'd1) begin
            state       <= RUN;
            cpu_start_q <= 1'b0;
            tcnt        <= 32'd0;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        RUN: begin
          // DONE has priority over a timeout landing in the same cycle.
          if (CPU_DONE) begin
            state       <= DUMP;
            dm_own_q    <= 1'b1;
            dm_addr_q   <= BASE;
            idx         <= 8'd0;
            out_valid_q <= 1'b1;
            out_last_q  <= (DUMP_LEN == 32'd1);
          end else if ((TIMEOUT != 32'd0) && (tcnt + 32'd1 == TIMEOUT)) begin
            state       <= IDLE;
            err_q       <= 1'b1;
            cpu_start_q <= 1'b1;
            dm_own_q    <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        DUMP: begin
          if (OUT_READY) begin
            if (idx == DUMP_LAST) begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              cpu_start_q <= 1'b1;
              busy_q      <= 1'b0;
              dm_addr_q   <= 8'd0;
            end else begin
              idx        <= idx + 8'd1;
              dm_addr_q  <= BASE + idx + 8'd1;
              out_last_q <= (idx + 8'd1 == DUMP_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_host_ctrl.sv
// Bench for dm_host_ctrl: two instances (default window, and a wrapping
// window with a short timeout) sharing the host stream, each with its own
// data memory model.
module tb_dm_host_ctrl;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, go_a, go_b, in_valid, in_last, done_a, done_b;
  logic       out_ready = 1'b1;
  logic [7:0] in_addr, in_data;
  logic       sel, toggle, dirty_a, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata;

  logic       ir_a, ov_a, ol_a, own_a, we_a, st_a, busy_a, err_a;
  logic [7:0] od_a, addr_a, wd_a, rd_a;
  logic       ir_b, ov_b, ol_b, own_b, we_b, st_b, busy_b, err_b;
  logic [7:0] od_b, addr_b, wd_b, rd_b;

  logic       ir_s, ov_s, ol_s, own_s, we_s, st_s, busy_s, err_s;
  logic [7:0] od_s, addr_s;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_host_ctrl u_a (
    .CLK(clk), .RESET(reset), .GO(go_a),
    .IN_VALID(in_valid), .IN_READY(ir_a), .IN_ADDR(in_addr), .IN_DATA(in_data), .IN_LAST(in_last),
    .OUT_VALID(ov_a), .OUT_READY(out_ready), .OUT_DATA(od_a), .OUT_LAST(ol_a),
    .DM_OWN(own_a), .DM_WE(we_a), .DM_ADDR(addr_a), .DM_WDATA(wd_a), .DM_RDATA(rd_a),
    .CPU_START(st_a), .CPU_DONE(done_a), .BUSY(busy_a), .ERR(err_a)
  );

  dm_host_ctrl #(.DUMP_BASE(254), .DUMP_LEN(4), .START_HOLD(2), .TIMEOUT(20)) u_b (
    .CLK(clk), .RESET(reset), .GO(go_b),
    .IN_VALID(in_valid), .IN_READY(ir_b), .IN_ADDR(in_addr), .IN_DATA(in_data), .IN_LAST(in_last),
    .OUT_VALID(ov_b), .OUT_READY(out_ready), .OUT_DATA(od_b), .OUT_LAST(ol_b),
    .DM_OWN(own_b), .DM_WE(we_b), .DM_ADDR(addr_b), .DM_WDATA(wd_b), .DM_RDATA(rd_b),
    .CPU_START(st_b), .CPU_DONE(done_b), .BUSY(busy_b), .ERR(err_b)
  );

  assign ir_s   = sel ? ir_b   : ir_a;
  assign ov_s   = sel ? ov_b   : ov_a;
  assign ol_s   = sel ? ol_b   : ol_a;
  assign own_s  = sel ? own_b  : own_a;
  assign we_s   = sel ? we_b   : we_a;
  assign st_s   = sel ? st_b   : st_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign err_s  = sel ? err_b  : err_a;
  assign od_s   = sel ? od_b   : od_a;
  assign addr_s = sel ? addr_b : addr_a;

  // Data memory models: combinational read, clocked write.
  assign rd_a = mem_a[addr_a];
  assign rd_b = mem_b[addr_b];

  always @(posedge clk) begin
    if (dirty_a) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 8'hAA;
    end else if (own_a && we_a) begin
      mem_a[addr_a] <= wd_a;
    end else if (!own_a && cpu_we) begin
      mem_a[cpu_addr] <= cpu_wdata;
    end
  end

  always @(posedge clk) begin
    if (own_b && we_b) mem_b[addr_b] <= wd_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Dump stream scoreboard; also checks data/last stay put while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (ov_s) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 32'(ov_s), 0);
      end else begin
        chk("dump_addr", 32'(addr_s), 32'(q[0].addr));
        chk("dump_data", 32'(od_s), 32'(q[0].data));
        chk("dump_last", 32'(ol_s), 32'(q[0].last));
        if (out_ready) e = q.pop_front();
      end
    end
  end

  // OUT_READY: high, or toggling every cycle when backpressure is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle ? ~out_ready : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_run(input logic b);
    int n;
    if (b) go_b = 1'b1; else go_a = 1'b1;
    tick();
    go_a = 1'b0;
    go_b = 1'b0;
    chk("go_clear_we", 32'(we_s), 1);
    chk("go_clear_addr", 32'(addr_s), 0);
    chk("go_busy", 32'(busy_s), 1);
    chk("go_err_clr", 32'(err_s), 0);
    n = 0;
    while (!ir_s && n < 400) begin
      tick();
      n++;
    end
    chk("clear_len", n, 256);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] d, input logic l);
    int g;
    g = 0;
    in_addr = a; in_data = d; in_last = l; in_valid = 1'b1;
    while (!ir_s && g < 50) begin
      tick();
      g++;
    end
    if (!ir_s) chk("in_ready_timeout", 32'(ir_s), 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Counts from the final beat's cycle to the first cycle with START low.
  task automatic wait_start_fall(output int n);
    chk("hold_own", 32'(own_s), 0);
    chk("hold_start", 32'(st_s), 1);
    n = 1;
    while (st_s && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    chk("dump_drained", q.size(), 0);
    chk("dump_end_busy", 32'(busy_s), 0);
    chk("dump_end_start", 32'(st_s), 1);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d, input logic l);
    exp_t e;
    e.addr = a; e.data = d; e.last = l;
    q.push_back(e);
  endtask

  initial begin
    int n;
    reset = 1'b1; go_a = 1'b0; go_b = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_addr = 8'd0; in_data = 8'd0; done_a = 1'b0; done_b = 1'b0;
    sel = 1'b0; toggle = 1'b0; dirty_a = 1'b0;
    cpu_we = 1'b0; cpu_addr = 8'd0; cpu_wdata = 8'd0;
    repeat (3) tick();
    chk("rst_start", 32'(st_a), 1);
    chk("rst_own", 32'(own_a), 1);
    chk("rst_we", 32'(we_a), 0);
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_wdata", 32'(wd_a), 0);
    chk("rst_in_ready", 32'(ir_a), 0);
    chk("rst_out_valid", 32'(ov_a), 0);
    chk("rst_out_last", 32'(ol_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_err", 32'(err_a), 0);
    reset = 1'b0;
    tick();

    // Preload, ignored GO in LOAD, CPU result dump.
    start_run(1'b0);
    send(8'd0, 8'd85, 1'b0);
    send(8'd1, 8'd5, 1'b0);
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    chk("go_in_load_busy", 32'(busy_s), 1);
    chk("go_in_load_ready", 32'(ir_s), 1);
    send(8'd2, 8'd85, 1'b0);
    send(8'd3, 8'd5, 1'b0);
    send(8'd2, 8'd99, 1'b0);
    for (int i = 0; i < 8; i++) send(8'(60 + i), 8'(240 + i), 1'b0);
    send(8'd68, 8'd255, 1'b1);
    wait_start_fall(n);
    chk("start_fall", n, 3);
    chk("pre_mem0", 32'(mem_a[0]), 85);
    chk("pre_mem1", 32'(mem_a[1]), 5);
    chk("pre_mem2_overwrite", 32'(mem_a[2]), 99);
    chk("pre_mem64", 32'(mem_a[64]), 244);
    chk("pre_mem68", 32'(mem_a[68]), 255);
    for (int i = 0; i < 4; i++) begin
      cpu_we = 1'b1; cpu_addr = 8'(5 + i); cpu_wdata = 8'(i + 1);
      push(8'(5 + i), 8'(i + 1), i == 3);
      tick();
    end
    cpu_we = 1'b0;
    repeat (46) tick();
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    chk("done_to_valid", 32'(ov_s), 1);
    n = 0;
    while (ov_s && n < 20) begin
      n++;
      tick();
    end
    chk("dump_cycles", n, 4);
    wait_drain();
    chk("run1_err", 32'(err_s), 0);

    // Clear coverage over a dirtied memory.
    dirty_a = 1'b1;
    tick();
    dirty_a = 1'b0;
    start_run(1'b0);
    send(8'd10, 8'd7, 1'b1);
    wait_start_fall(n);
    for (int i = 0; i < 4; i++) push(8'(5 + i), 8'd0, i == 3);
    repeat (10) tick();
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    wait_drain();
    for (int i = 0; i < 256; i++) chk("clear_mem", 32'(mem_a[i]), (i == 10) ? 7 : 0);

    // Reset during RUN.
    start_run(1'b0);
    send(8'd0, 8'd1, 1'b1);
    wait_start_fall(n);
    repeat (5) tick();
    chk("run_start_low", 32'(st_s), 0);
    reset = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy_s), 0);
    chk("midrst_start", 32'(st_s), 1);
    chk("midrst_own", 32'(own_s), 1);
    reset = 1'b0;
    tick();
    chk("midrst_idle", 32'(busy_s), 0);

    // Timeout on the short-timeout instance.
    sel = 1'b1;
    start_run(1'b1);
    send(8'd3, 8'd3, 1'b1);
    wait_start_fall(n);
    chk("start_fall_b", n, 3);
    n = 0;
    while (!err_s && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 20);
    chk("timeout_busy", 32'(busy_s), 0);
    chk("timeout_start", 32'(st_s), 1);
    chk("timeout_own", 32'(own_s), 1);

    // DONE on the timeout cycle, wrapping window, toggling backpressure.
    start_run(1'b1);
    send(8'd254, 8'd11, 1'b0);
    send(8'd255, 8'd12, 1'b0);
    send(8'd0, 8'd13, 1'b0);
    send(8'd1, 8'd14, 1'b1);
    wait_start_fall(n);
    repeat (19) tick();
    push(8'd254, 8'd11, 1'b0);
    push(8'd255, 8'd12, 1'b0);
    push(8'd0, 8'd13, 1'b0);
    push(8'd1, 8'd14, 1'b1);
    done_b = 1'b1;
    toggle = 1'b1;
    tick();
    done_b = 1'b0;
    chk("simul_valid", 32'(ov_s), 1);
    chk("simul_err", 32'(err_s), 0);
    wait_drain();
    toggle = 1'b0;
    chk("simul_err_end", 32'(err_s), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
